// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: latches one 128-bit state, transforms COLS_PER_CYCLE
// columns per clock in GF(2^8), then holds the result until the consumer takes it.
module inv_mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [1:0]   dbg_state_o
);

   // Handshakes: a beat transfers on a rising edge where valid && ready are both high.
   // in_ready depends only on state; out_valid/out_data stay stable until out_ready.

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0][31:0]  work_q, work_d;   // column c lives at work_q[3-c]

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      work_d  = work_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               idx_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            // ~(idx+k) maps column number to its packed slot (column 0 is the MSB word)
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               work_d[~(idx_q + 2'(k))] = inv_mix_col(work_q[~(idx_q + 2'(k))]);
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDX_STEP;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign out_data    = work_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: known AES vectors, latency, backpressure,
// mid-operation reset, back-to-back streaming and a MixColumns round trip.
module tb_inv_mix_columns_seq;

   localparam int CPC      = 1;
   localparam int CALC_CYC = 4 / CPC;

   localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] PC_IN    = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
   localparam logic [127:0] PC_OUT   = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] V2_IN    = 128'hd5d5d7d64d7ebdf800000000ffffffff;
   localparam logic [127:0] V2_OUT   = 128'hd4d4d4d52d26314c00000000ffffffff;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic [127:0] out_data;
   logic         busy;
   logic [1:0]   dbg_state;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int n_xfer = 0;
   int t_acc = 0;
   logic [127:0] exp_q[$];

   inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required earlier finish", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // generic GF(2^8) multiply (shift-and-add) used by the reference models
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p = '0;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // circulant matrix product; base holds row 0 coefficients
   function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [31:0] base);
      logic [127:0] r;
      logic [7:0]   acc;
      logic [7:0]   cf;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
               int m;
               m = (j - row + 4) % 4;
               cf = base[31-8*m -: 8];
               acc = acc ^ gmul(cf, s[127-32*c-8*j -: 8]);
            end
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // scoreboard: every completed output handshake is compared with the queue head
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_xfer <= n_xfer + 1;
         if (exp_q.size() == 0) check("unexpected_out", 128'(exp_q.size()), 128'd1);
         else check("out_data", out_data, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [127:0] d, input logic [127:0] e);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      t_acc    = cyc;
      in_valid = 1'b0;
      in_data  = rand128();
      exp_q.push_back(e);
   endtask

   task automatic wait_valid(output int c);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("valid_timeout", 128'(out_valid), 128'd1);
      c = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 128'(exp_q.size()), 128'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c;
      int x0;
      int acc_t[8];
      logic [127:0] sv[8];
      logic [127:0] s;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_state", 128'(dbg_state), 128'd0);

      // FIPS round vector, latency, then backpressure in DONE
      out_ready = 1'b0;
      drive(FIPS_IN, FIPS_OUT);
      check("busy_calc", 128'(busy), 128'd1);
      check("in_ready_calc", 128'(in_ready), 128'd0);
      wait_valid(c);
      check("latency", 128'(c + 1 - t_acc), 128'(1 + CALC_CYC));
      in_valid = 1'b1;
      in_data  = PC_IN;
      repeat (10) begin
         check("bp_out_valid", 128'(out_valid), 128'd1);
         check("bp_out_data", out_data, FIPS_OUT);
         check("bp_in_ready", 128'(in_ready), 128'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x0 = n_xfer;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_in_ready_after", 128'(in_ready), 128'd1);
      check("bp_out_valid_after", 128'(out_valid), 128'd0);
      check("bp_one_transfer", 128'(n_xfer - x0), 128'd1);

      // per-column vectors
      drive(PC_IN, PC_OUT);
      drive(V2_IN, V2_OUT);
      drain();

      // reset during the second CALC cycle
      drive(FIPS_IN, FIPS_OUT);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      check("mid_rst_out_data", out_data, 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      x0 = n_xfer;
      repeat (12) @(negedge clk);
      check("mid_rst_no_stale", 128'(n_xfer - x0), 128'd0);
      drive(V2_IN, V2_OUT);
      drain();

      // back-to-back streaming with in_valid held high
      for (int i = 0; i < 8; i++) sv[i] = rand128();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = sv[0];
      for (int i = 0; i < 8; i++) begin
         int n;
         n = 0;
         while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!in_ready) check("stream_accept_timeout", 128'(in_ready), 128'd1);
         @(posedge clk);
         #1;
         acc_t[i] = cyc;
         exp_q.push_back(mix_model(sv[i], 32'h0e0b0d09));
         if (i < 7) in_data = sv[i+1];
         else in_valid = 1'b0;
      end
      for (int i = 1; i < 8; i++) begin
         check("stream_gap", 128'(acc_t[i] - acc_t[i-1]), 128'(CALC_CYC + 2));
      end
      drain();

      // round trip through forward MixColumns
      for (int i = 0; i < 100; i++) begin
         s = rand128();
         drive(mix_model(s, 32'h02030101), s);
      end
      drain();
      check("final_in_ready", 128'(in_ready), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Iterative AES InvMixColumns unit for the decryption datapath; the inverse of the combinational MixColumns stage.
- Accepts one 128-bit state through a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock in GF(2^8).
- Presents the result through an output valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative decryption round.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is a synthesis-time error.

Ports:
clk        input   1    rising-edge clock
rst        input   1    synchronous, active-high reset
in_valid   input   1    in_data valid
in_ready   output  1    block can accept a state
in_data    input   128  state, column-major; column c = in_data[127-32c -: 32]; byte 0 of each column is MSB
out_valid  output  1    out_data holds a completed result
out_ready  input   1    downstream accepts out_data
out_data   output  128  InvMixColumns(in_data), same packing as in_data
busy       output  1    high in CALC or DONE

Behaviour:
- Reset (rst high at a rising edge), from any state including mid-CALC or DONE:
  - state goes to IDLE; column counter = 0; work register = 0.
  - out_data = 0, out_valid = 0, busy = 0, in_ready = 1 in the following cycle.
  - The in-flight block is discarded; no partial result is ever presented.
- FSM IDLE -> CALC -> DONE -> IDLE:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch in_data into the work register, clear the counter, go to CALC.
  - CALC: in_ready = 0. Each cycle, replace columns idx .. idx+COLS_PER_CYCLE-1 of the work register with their transformed values; idx += COLS_PER_CYCLE. After column 3 is written, go to DONE. CALC lasts 4/COLS_PER_CYCLE cycles.
  - DONE: out_valid = 1; out_data = work register, held stable while out_ready = 0. On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: with the accept edge at cycle T, out_valid is high at cycle T+1+4/COLS_PER_CYCLE (T+5 at the default).
- Throughput: one block per 4/COLS_PER_CYCLE + 2 cycles when out_ready is tied high.
- in_ready is a pure function of state and does not depend on in_valid. in_data is ignored outside the accept cycle.
- out_data changes only on accept into CALC, during CALC updates, or on reset. Its value outside DONE is don't-care to consumers but deterministic.
- Column math, input (a0,a1,a2,a3) with a0 the MSB:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- GF(2^8) arithmetic:
  - Multiplication is built from xtime, reducing modulo x^8+x^4+x^3+x+1 (0x11B); no lookup tables.
  - x2 = xtime(a), x4 = xtime(x2), x8 = xtime(x4).
  - 09 = x8^a, 0b = x8^x2^a, 0d = x8^x4^a, 0e = x8^x4^x2.
  - All products are 8 bits wide; no carries leave a byte.
- Simultaneous events: rst wins over any handshake. In DONE, in_valid is ignored; a new block is accepted only from IDLE.

Test Plan:
- FIPS-197 round vector: in_data = 046681e5e0cb199a48f8d37a2806264c -> out_data = d4bf5d30e0b452aeb84111f11e2798e5. out_valid is first high exactly 5 cycles after the accept edge.
- Per-column vectors: in_data = 8e4da1bc9fdc589d01010101c6c6c6c6 -> out_data = db135345f20a225c01010101c6c6c6c6. A second block, in_data = d5d5d7d64d7ebdf800000000ffffffff -> out_data = d4d4d4d52d26314c00000000ffffffff.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid stays 1, out_data stays constant, in_ready stays 0. On out_ready = 1, exactly one transfer occurs and in_ready returns to 1 the next cycle.
- Reset mid-operation: assert rst for one cycle in the 2nd CALC cycle -> next cycle out_valid = 0, out_data = 0, busy = 0, in_ready = 1. No stale result appears afterwards. A fresh vector then completes correctly.
- Back-to-back streaming: out_ready tied high, in_valid always high, 8 random states -> every output matches the software model. Spacing is 6 cycles per block for COLS_PER_CYCLE = 1, 4 for 2, and 3 for 4.
- Round trip: feed each output of the existing MixColumns module for 100 random states -> out_data equals the original state.
